// File: rtl/pin_input_filter.sv
`default_nettype none
// ============================================================================
// Module   : pin_input_filter
// Brief    : Per-pin two-flop synchroniser with optional glitch filter and
//            registered rise/fall event pulses for raw padring inputs.
// Revision : 1.0 - initial release
// ============================================================================
module pin_input_filter #(
    parameter int   NumberOfPins = 1,
    parameter int   FilterCycles = 4,
    parameter logic ResetValue   = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic pins_i      [NumberOfPins],
    input  logic filter_en_i [NumberOfPins],
    output logic pins_o      [NumberOfPins],
    output logic rise_o      [NumberOfPins],
    output logic fall_o      [NumberOfPins]
);

    localparam int c_cnt_w = (FilterCycles > 1) ? $clog2(FilterCycles) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_term = c_cnt_w'(FilterCycles - 1);

    for (genvar p = 0; p < NumberOfPins; p++) begin : g_pin
        (* ASYNC_REG = "TRUE" *) logic r_sync1;
        (* ASYNC_REG = "TRUE" *) logic r_sync2;
        logic               r_filt;
        logic               r_rise;
        logic               r_fall;
        logic [c_cnt_w-1:0] r_cnt;
        logic               w_differs;
        logic               w_accept;

        // A disabled filter accepts any difference at once, like FilterCycles=1.
        assign w_differs = (r_sync2 != r_filt);
        assign w_accept  = w_differs && (!filter_en_i[p] || (r_cnt == c_cnt_term));

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                r_sync1 <= ResetValue;
                r_sync2 <= ResetValue;
                r_filt  <= ResetValue;
                r_cnt   <= '0;
                r_rise  <= 1'b0;
                r_fall  <= 1'b0;
            end else begin
                r_sync1 <= pins_i[p];
                r_sync2 <= r_sync1;
                r_rise  <= w_accept && r_sync2;
                r_fall  <= w_accept && !r_sync2;
                if (w_accept) begin
                    r_filt <= r_sync2;
                end
                // Progress is lost whenever the input agrees again or the filter is off.
                if (!filter_en_i[p] || !w_differs || w_accept) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end

        assign pins_o[p] = r_filt;
        assign rise_o[p] = r_rise;
        assign fall_o[p] = r_fall;
    end

endmodule
`default_nettype wire

// File: doc/pin_input_filter.md
# pin_input_filter

Per-pin input conditioning stage sitting directly downstream of the FPGA padring. It takes the raw pad input bits (`from_pins_o` of the padring), synchronises each into the system clock domain and optionally debounces it with a per-pin glitch filter. It presents clean levels plus single-cycle rising/falling event pulses to GPIO, pinmux and peripheral logic. All pins are independent; no cross-pin state exists.

## Interface

Parameters:
- `NumberOfPins`, 1, number of pins conditioned; matches the padring instance.
- `FilterCycles`, 4, consecutive cycles the synchronised value must differ from the filtered value before the filtered value changes; legal range 1..65536.
- `ResetValue`, 1'b0, value loaded into every synchroniser and filtered-state flop on reset.

Ports:
- `clk_i`  input  1  system clock; single clock domain.
- `rst_i`  input  1  reset; synchronous, active-high.
- `pins_i`  input  1 x [NumberOfPins] (unpacked)  raw pad inputs, asynchronous to `clk_i`.
- `filter_en_i`  input  1 x [NumberOfPins] (unpacked)  per-pin filter enable; quasi-static, synchronous to `clk_i`.
- `pins_o`  output  1 x [NumberOfPins] (unpacked)  filtered level.
- `rise_o`  output  1 x [NumberOfPins] (unpacked)  one-cycle pulse, asserted with a 0->1 change of `pins_o`.
- `fall_o`  output  1 x [NumberOfPins] (unpacked)  one-cycle pulse, asserted with a 1->0 change of `pins_o`.

## Operation

Per pin p:
- Synchroniser: two flops `s1 <= pins_i[p]`, `s2 <= s1`. Only `s2` feeds downstream logic. Mark both flops for async-register placement.
- State: filtered flop `filt` (drives `pins_o[p]`), counter `cnt` of width max(1, $clog2(FilterCycles)), and registered `rise`/`fall` flops.
- Filter enabled (`filter_en_i[p]=1`), evaluated each rising edge:
  - `s2 == filt`: `cnt <= 0`.
  - `s2 != filt` and `cnt == FilterCycles-1`: `filt <= s2`, `cnt <= 0`, pulse `rise` or `fall` according to `s2`.
  - `s2 != filt` otherwise: `cnt <= cnt+1`.
  - Any return of `s2` to `filt` before the terminal count discards progress. A glitch shorter than FilterCycles synchronised cycles never reaches `pins_o`.
- Filter disabled: `filt <= s2` every edge, `cnt <= 0`, pulses are generated on every change. This is identical to the FilterCycles=1 behaviour.
- Toggling `filter_en_i` mid-count: 1->0 clears `cnt`; the next edge follows `s2`. 0->1 starts counting from 0.
- `rise_o`/`fall_o` are registered and are high for exactly the one cycle in which `pins_o` holds the new value. They are never both high, and are never high without a `pins_o` change.
- Counter arithmetic never wraps: `cnt` is bounded to FilterCycles-1 by the terminal-count rule.

## Timing

- Reset (`rst_i` high at an edge): `s1`, `s2` and `filt` load `ResetValue`, `cnt` loads 0, and `rise`/`fall` load 0. After that edge, `pins_o = ResetValue` and `rise_o = fall_o = 0`.
- Reset mid-count aborts the count. No pulse is emitted on reset entry or exit, even if `filt` changes value due to reset.
- A pin held at `ResetValue` through reset release produces no events.
- Latency, input stable from sampling edge E0: `s2` is valid after E1. `pins_o`, `rise_o` or `fall_o` update at edge E(FilterCycles+1).
  - Filter disabled: update at E2.
- Throughput: one accepted change per FilterCycles cycles per pin at most.
- No combinational path from any input to any output.

## Test plan

- **Reset:** ResetValue=1, `pins_i` all 1, `rst_i` high 3 cycles then low. Required: `pins_o`=1 throughout and after, `rise_o`/`fall_o` never asserted.
- **Clean edge, FilterCycles=4, filter on:** `pins_i` 0->1 at E0 and held. Required: `pins_o` rises at E5, `rise_o`=1 for exactly cycle E5..E6, `fall_o`=0.
- **Glitch rejection, FilterCycles=4:** high pulses of 1, 2 and 3 cycles separated by 6 low cycles. Required: `pins_o` stays 0 and no pulses. A 4-cycle pulse yields one `rise_o` and, after release, one `fall_o` 4 cycles later.
- **Bypass:** `filter_en_i`=0, toggle `pins_i` every 2 cycles. Required: `pins_o` follows with 2-edge latency, one pulse per transition. Then set `filter_en_i`=1 mid-count and check the count restarts from 0.
- **Reset mid-count:** start a 0->1 transition, assert `rst_i` at the third counting cycle with ResetValue=0, release, keep input high. Required: no pulse during reset. `rise_o` asserts exactly FilterCycles+1 edges after release.
- **Independence:** NumberOfPins=4 with staggered, simultaneous and glitchy stimulus on different pins. Required: each pin's outputs match a per-pin reference model cycle-exactly, and simultaneous edges produce simultaneous pulses.
